// File: rtl/portfolio_valuator.sv
// Purpose: values a latched 3-asset weight vector against each price tick (sum w*p) and its change vs the prior tick.
// Latency: accept at T, value_valid at T+N_ASSETS+1; one tick per N_ASSETS+2 cycles through one shared multiplier.
// Backpressure: price_ready is low until weights exist and while a tick is in flight; ticks are never queued.
module portfolio_valuator #(
    parameter int N_ASSETS = 3,
    parameter int WIDTH    = 16,
    parameter int ACC_W    = 34
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 weights_valid,
    input  logic signed [N_ASSETS-1:0][WIDTH-1:0] weights,
    input  logic                                 price_valid,
    input  logic signed [N_ASSETS-1:0][WIDTH-1:0] prices,
    output logic                                 price_ready,
    output logic                                 value_valid,
    output logic signed [31:0]                   value,
    output logic signed [31:0]                   delta,
    output logic                                 first
);

    localparam int IDX_W = (N_ASSETS > 1) ? $clog2(N_ASSETS) : 1;
    localparam logic signed [ACC_W-1:0] MAX32 = ACC_W'(64'sh0000_0000_7FFF_FFFF);
    localparam logic signed [ACC_W-1:0] MIN32 = ACC_W'(-64'sh0000_0000_8000_0000);

    typedef enum logic [1:0] {NO_W, RDY, MAC, OUT} state_t;

    state_t                           state;
    logic [N_ASSETS-1:0][WIDTH-1:0]   pend_w;
    logic [N_ASSETS-1:0][WIDTH-1:0]   act_w;
    logic [N_ASSETS-1:0][WIDTH-1:0]   price_q;
    logic                             pend;
    logic                             has_prev;
    logic [IDX_W-1:0]                 idx;
    logic signed [ACC_W-1:0]          acc;
    logic signed [31:0]               prev;

    logic signed [2*WIDTH-1:0]        prod;
    logic signed [31:0]               value_nx;
    logic signed [ACC_W-1:0]          diff;
    logic signed [31:0]               delta_nx;

    function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] x);
        if (x > MAX32) begin
            sat32 = 32'sh7FFF_FFFF;
        end else if (x < MIN32) begin
            sat32 = 32'sh8000_0000;
        end else begin
            sat32 = x[31:0];
        end
    endfunction

    always_comb begin
        prod     = $signed(act_w[idx]) * $signed(price_q[idx]);
        value_nx = sat32(acc);
        // Difference taken at accumulator width so two saturated extremes cannot wrap.
        diff     = ACC_W'(value_nx) - ACC_W'(prev);
        delta_nx = sat32(diff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NO_W;
            price_ready <= 1'b0;
            value_valid <= 1'b0;
            value       <= '0;
            delta       <= '0;
            first       <= 1'b0;
            pend        <= 1'b0;
            pend_w      <= '0;
            act_w       <= '0;
            price_q     <= '0;
            has_prev    <= 1'b0;
            prev        <= '0;
            acc         <= '0;
            idx         <= '0;
        end else begin
            value_valid <= 1'b0;
            case (state)
                NO_W: begin
                    if (pend) begin
                        state       <= RDY;
                        price_ready <= 1'b1;
                    end
                end
                RDY: begin
                    if (price_valid) begin
                        price_ready <= 1'b0;
                        price_q     <= prices;
                        // Pending weights take over at a tick boundary and restart the delta baseline.
                        if (pend) begin
                            act_w    <= pend_w;
                            pend     <= 1'b0;
                            has_prev <= 1'b0;
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N_ASSETS - 1)) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    value <= value_nx;
                    if (has_prev) begin
                        delta <= delta_nx;
                        first <= 1'b0;
                    end else begin
                        delta <= '0;
                        first <= 1'b1;
                    end
                    prev        <= value_nx;
                    has_prev    <= 1'b1;
                    value_valid <= 1'b1;
                    price_ready <= 1'b1;
                    state       <= RDY;
                end
                default: begin
                    state       <= NO_W;
                    price_ready <= 1'b0;
                end
            endcase
            // Placed last so a pulse coinciding with an accept stays pending for the next tick.
            if (weights_valid) begin
                pend_w <= weights;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_portfolio_valuator.sv
// Directed-vector bench for portfolio_valuator with hand-computed expected values.
module tb_portfolio_valuator;

    logic              clk;
    logic              rst;
    logic              weights_valid;
    logic [2:0][15:0]  weights;
    logic              price_valid;
    logic [2:0][15:0]  prices;
    logic              price_ready;
    logic              value_valid;
    logic [31:0]       value;
    logic [31:0]       delta;
    logic              first;

    int n_cmp = 0;
    int n_bad = 0;

    portfolio_valuator #(.N_ASSETS(3), .WIDTH(16), .ACC_W(34)) dut (
        .clk           (clk),
        .rst           (rst),
        .weights_valid (weights_valid),
        .weights       (weights),
        .price_valid   (price_valid),
        .prices        (prices),
        .price_ready   (price_ready),
        .value_valid   (value_valid),
        .value         (value),
        .delta         (delta),
        .first         (first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0][15:0] pk(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2);
        pk = {a2, a1, a0};
    endfunction

    task automatic pulse_weights(input logic [2:0][15:0] w);
        weights_valid = 1'b1;
        weights       = w;
        @(negedge clk);
        weights_valid = 1'b0;
    endtask

    // mode 0: plain tick; 1: weights pulse on the accept edge; 2: two weights pulses during MAC.
    task automatic do_tick(input string tag, input logic [2:0][15:0] p, input int mode,
                           input logic [2:0][15:0] wa, input logic [2:0][15:0] wb,
                           input logic [31:0] ev, input logic [31:0] ed, input logic ef);
        int   k;
        logic got;
        price_valid = 1'b1;
        prices      = p;
        k = 0;
        while (!price_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 32'(price_ready), 32'd1);
        if (mode == 1) begin
            weights_valid = 1'b1;
            weights       = wa;
        end
        @(posedge clk);
        @(negedge clk);
        price_valid   = 1'b0;
        prices        = 48'hDEAD_BEEF_1234;
        weights_valid = 1'b0;
        if (mode == 2) begin
            weights_valid = 1'b1;
            weights       = wa;
        end
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (mode == 2 && k == 1) weights = wb;
            if (mode == 2 && k == 2) weights_valid = 1'b0;
            got = value_valid;
        end
        check({tag, "_vld"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(k), 32'd4);
        check({tag, "_value"}, value, ev);
        check({tag, "_delta"}, delta, ed);
        check({tag, "_first"}, 32'(first), 32'(ef));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(value_valid), 32'd0);
    endtask

    logic [2:0][15:0] w_basic, w_neg, w_half, w_max, w_mix, p256, p512, zero_w;
    int cnt;

    initial begin
        w_basic = pk(16'd32, 16'd88, 16'd134);
        w_neg   = pk(16'd106, 16'hFED6, 16'd448);
        w_half  = pk(16'd128, 16'd0, 16'd0);
        w_max   = pk(16'h7FFF, 16'h7FFF, 16'h7FFF);
        w_mix   = pk(16'h8000, 16'h7FFF, 16'h7FFF);
        p256    = pk(16'd256, 16'd256, 16'd256);
        p512    = pk(16'd512, 16'd512, 16'd512);
        zero_w  = '0;

        rst = 1'b1; weights_valid = 1'b0; weights = '0; price_valid = 1'b0; prices = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(price_ready), 32'd0);
        check("rst_vld", 32'(value_valid), 32'd0);
        check("rst_value", value, 32'd0);
        check("rst_delta", delta, 32'd0);
        check("rst_first", 32'(first), 32'd0);

        // Ticks offered before any weights are never accepted.
        price_valid = 1'b1; prices = p256;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (price_ready || value_valid) cnt++;
        end
        check("noweights_activity", 32'(cnt), 32'd0);

        pulse_weights(w_basic);
        do_tick("basic", p256, 0, zero_w, zero_w, 32'd65024, 32'd0, 1'b1);
        do_tick("up", p512, 0, zero_w, zero_w, 32'd130048, 32'd65024, 1'b0);
        do_tick("down", p256, 0, zero_w, zero_w, 32'd65024, -32'sd65024, 1'b0);

        repeat (2) @(negedge clk);
        check("hold_value", value, 32'd65024);
        check("hold_delta", delta, -32'sd65024);
        check("hold_vld", 32'(value_valid), 32'd0);

        pulse_weights(w_neg);
        do_tick("neg", p256, 0, zero_w, zero_w, 32'd65536, 32'd0, 1'b1);

        // Pulse on the accept edge: this tick still uses w_neg, the next one w_basic.
        do_tick("same_edge", p256, 1, w_basic, zero_w, 32'd65536, 32'd0, 1'b0);
        do_tick("after_same", p256, 0, zero_w, zero_w, 32'd65024, 32'd0, 1'b1);

        // Two pulses during MAC: in-flight tick unaffected, last pulse wins.
        do_tick("mid_mac", p256, 2, w_neg, w_half, 32'd65024, 32'd0, 1'b0);
        do_tick("last_wins", p256, 0, zero_w, zero_w, 32'd32768, 32'd0, 1'b1);

        pulse_weights(w_max);
        do_tick("sat_pos", w_max, 0, zero_w, zero_w, 32'h7FFF_FFFF, 32'd0, 1'b1);
        pulse_weights(w_mix);
        do_tick("sat_neg", pk(16'h7FFF, 16'h8000, 16'h8000), 0, zero_w, zero_w,
                32'h8000_0000, 32'd0, 1'b1);
        do_tick("sat_delta", pk(16'h8000, 16'h7FFF, 16'h7FFF), 0, zero_w, zero_w,
                32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);

        // Reset landing on the second MAC cycle discards the tick.
        pulse_weights(w_basic);
        price_valid = 1'b1; prices = p256;
        cnt = 0;
        while (!price_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rstmac_ready", 32'(price_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (value_valid || price_ready) cnt++;
        end
        check("rstmac_activity", 32'(cnt), 32'd0);
        check("rstmac_value", value, 32'd0);
        check("rstmac_delta", delta, 32'd0);
        check("rstmac_first", 32'(first), 32'd0);

        pulse_weights(w_basic);
        do_tick("post_rst", p256, 0, zero_w, zero_w, 32'd65024, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/portfolio_valuator.md
Name: portfolio_valuator

Overview:
- Downstream consumer of `eigenportfolio`. Latches the normalized 3-asset weight vector when `eigenportfolio` asserts `done`.
- Values the portfolio on every incoming price tick: value = Σ wᵢ·pᵢ, computed by a single time-shared multiplier.
- Emits the value and its change versus the previous tick. These feed the trading/signal logic.

Parameters:
- N_ASSETS, 3, number of assets; fixed to match `eigenportfolio`.
- WIDTH, 16, bit width of each weight and price (signed Q8.8).
- ACC_W, 34, internal accumulator width (2·WIDTH + 2 guard bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- weights_valid  in  1  one-cycle pulse; driven by eigenportfolio `done`
- weights  in  [N_ASSETS-1:0][WIDTH-1:0] signed  Q8.8 weights; eigenportfolio `portfolio`
- price_valid  in  1  price tick offered
- prices  in  [N_ASSETS-1:0][WIDTH-1:0] signed  Q8.8 per-asset prices
- price_ready  out  1  block can accept a tick
- value_valid  out  1  one-cycle pulse when value/delta are updated
- value  out  [31:0] signed  portfolio value, Q16.16, saturated
- delta  out  [31:0] signed  value minus previous value, Q16.16, saturated
- first  out  1  high with value_valid when no baseline existed (delta forced to 0)

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=NO_W; price_ready=0, value_valid=0, value=0, delta=0, first=0.
  - Pending/active weights cleared; has_prev=0.
  - rst mid-MAC discards the in-flight tick with no value_valid.
- Weight capture: weights_valid=1 at a posedge copies `weights` into the pending register and sets pend=1, in any state. A later pulse overwrites an earlier one (last wins).
- Handshake: a tick is accepted on a posedge with price_valid && price_ready. Prices are registered at acceptance; the input may change afterwards.
- States:
  - NO_W: price_ready=0. On pend=1, go to RDY.
  - RDY: price_ready=1. On accept:
    - If pend=1: active←pending, pend←0, has_prev←0.
    - Clear acc; idx←0; go to MAC.
  - MAC: price_ready=0. Each cycle: acc += sext(active[idx]) × sext(price_q[idx]), a full 32-bit signed product; idx++. After the N_ASSETS-th product, go to OUT.
  - OUT: compute outputs, then return to RDY.
    - value ← sat32(acc).
    - If has_prev=0: delta←0, first←1.
    - Otherwise: delta←sat32(value_new − prev) at ACC_W width, first←0.
    - prev←value_new; has_prev←1.
    - value_valid=1 for exactly this cycle.
- Latency: accept at cycle T, value_valid at T+N_ASSETS+1 (T+4). Throughput is one tick per 5 cycles.
- value/delta/first hold between pulses.
- Saturation: results above 2³¹−1 clamp to 0x7FFFFFFF; results below −2³¹ clamp to 0x80000000. No wrap-around.
- Simultaneous weights_valid and price accept on the same edge: the accepted tick uses the old active weights. The new weights go to pending and take effect on the next accept.
- A weights_valid during MAC/OUT does not disturb the in-flight computation.
- A weight update always restarts the delta baseline: the next output has first=1, delta=0.
- price_valid while price_ready=0: ignored, never queued. The source holds price_valid until ready.

Test Plan:
- Basic valuation: reset; weights={32,88,134} pulse; price {256,256,256} → value_valid exactly 4 cycles after accept; value=65024 (0.9921875), delta=0, first=1.
- Delta tracking: after the above, price {512,512,512} → value=130048, delta=65024, first=0. Then {256,256,256} → value=65024, delta=−65024.
- Negative weights: weights={106,16'hFED6(−298),448}; price {256,256,256} → value=65536 (1.0), first=1. Confirms signed products.
- Saturation: weights={7FFF×3}, prices={7FFF×3} → value=0x7FFFFFFF. Then weights={8000,7FFF,7FFF}, prices={7FFF,8000,8000} → value=0x80000000. The next positive-saturated tick gives delta=0x7FFFFFFF.
- Handshake/ordering: price_valid held before any weights → price_ready=0, no output. A weights_valid pulse on the same edge as an accept → current output uses old weights; the next tick uses new weights with first=1. A second weights pulse during MAC → last-written weights are used next.
- Reset mid-op: assert rst during MAC cycle 2 → no value_valid; all outputs 0; price_ready=0 until a new weights_valid.
